// File: rtl/dds_pkg.sv
// Shared types and default sizes for the multi-waveform DDS generator.
package dds_pkg;

  localparam int DEF_ACC_W  = 24;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_DIV_W  = 8;

  typedef enum logic [1:0] {
    WAVE_SIN = 2'd0,
    WAVE_SQR = 2'd1,
    WAVE_TRI = 2'd2,
    WAVE_SAW = 2'd3
  } wave_sel_t;

endpackage

// File: rtl/dds_wave_gen_if.sv
// Control, configuration, sine-ROM and sample-stream signals of dds_wave_gen.
interface dds_wave_gen_if
  import dds_pkg::*;
#(
  parameter int ACC_W  = DEF_ACC_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DIV_W  = DEF_DIV_W
);

  logic              en;
  logic              sync_clr;
  logic              cfg_load;
  logic [ACC_W-1:0]  f_word;
  logic [ADDR_W-1:0] p_word;
  wave_sel_t         wave_sel;
  logic [DIV_W-1:0]  div_ratio;
  logic              cfg_ack;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_q;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;

  // Controller and ROM side.
  modport master (
    output en, sync_clr, cfg_load, f_word, p_word, wave_sel, div_ratio, rom_q,
    input  cfg_ack, rom_addr, data_out, data_valid
  );

  // Generator side.
  modport slave (
    input  en, sync_clr, cfg_load, f_word, p_word, wave_sel, div_ratio, rom_q,
    output cfg_ack, rom_addr, data_out, data_valid
  );

endinterface

// File: rtl/dds_tick_div.sv
// Sample-rate divider: one tick every div_act+1 enabled cycles.
module dds_tick_div #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync_clr,
  input  logic             restart,
  input  logic [DIV_W-1:0] div_act,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  // Kept apart from the counter update so restart (derived from tick) forms no loop.
  assign tick = en && !sync_clr && (cnt_q == div_act);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    cnt_d = cnt_q;
    if (sync_clr || restart || tick) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dds_wave_gen.sv
// DDS waveform generator: phase accumulator, atomic config swap, 3-stage sample pipeline.
module dds_wave_gen
  import dds_pkg::*;
#(
  parameter int ACC_W  = DEF_ACC_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DIV_W  = DEF_DIV_W
) (
  input logic           clk,
  input logic           rst_n,
  dds_wave_gen_if.slave bus
);

  typedef struct packed {
    logic [ACC_W-1:0]  f;
    logic [ADDR_W-1:0] p;
    wave_sel_t         w;
    logic [DIV_W-1:0]  div;
  } cfg_t;

  cfg_t              pend_q, pend_d, act_q, act_d, eff;
  logic              pend_vld_q, pend_vld_d;
  logic              tick, apply;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ADDR_W-1:0] ph_q, ph_d, ph2_q, ph2_d;
  wave_sel_t         w1_q, w1_d, w2_q, w2_d;
  logic              v1_q, v1_d, v2_q, v2_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              ack_q, ack_d;

  // Left-justify a phase index into a sample word (pad or truncate LSBs).
  function automatic logic [DATA_W-1:0] scale(input logic [ADDR_W-1:0] x);
    logic [ADDR_W+DATA_W-1:0] wide;
    wide = {x, {DATA_W{1'b0}}};
    return wide[ADDR_W+DATA_W-1 -: DATA_W];
  endfunction

  function automatic logic [DATA_W-1:0] shape(input wave_sel_t w,
                                              input logic [ADDR_W-1:0] ph,
                                              input logic [DATA_W-1:0] rom);
    logic [ADDR_W-1:0] t;
    logic [DATA_W-1:0] s;
    t = ph << 1;
    s = scale(ph);
    case (w)
      WAVE_SIN: s = rom;
      WAVE_SQR: s = ph[ADDR_W-1] ? '1 : '0;
      WAVE_TRI: s = scale(ph[ADDR_W-1] ? ~t : t);
      WAVE_SAW: s = scale(ph);
      default:  s = scale(ph);
    endcase
    return s;
  endfunction

  dds_tick_div #(.DIV_W(DIV_W)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (bus.en),
    .sync_clr (bus.sync_clr),
    .restart  (apply),
    .div_act  (act_q.div),
    .tick     (tick)
  );

  always_comb begin
    apply = pend_vld_q && (tick || !bus.en);
    // The applying tick already runs on the new config.
    eff   = apply ? pend_q : act_q;
    act_d = eff;
    ack_d = apply;

    pend_d     = pend_q;
    pend_vld_d = pend_vld_q && !apply;
    if (bus.cfg_load) begin
      pend_d.f   = bus.f_word;
      pend_d.p   = bus.p_word;
      pend_d.w   = bus.wave_sel;
      pend_d.div = bus.div_ratio;
      pend_vld_d = 1'b1;
    end

    acc_d = acc_q;
    if (bus.sync_clr) begin
      acc_d = '0;
    end else if (tick) begin
      acc_d = acc_q + eff.f;
    end

    // Stage 1 samples the pre-increment accumulator.
    ph_d = ph_q;
    w1_d = w1_q;
    v1_d = tick;
    if (tick) begin
      ph_d = acc_q[ACC_W-1 -: ADDR_W] + eff.p;
      w1_d = eff.w;
    end

    ph2_d = ph_q;
    w2_d  = w1_q;
    v2_d  = v1_q;

    data_d  = data_q;
    valid_d = v2_q;
    if (v2_q) begin
      data_d = shape(w2_q, ph2_q, bus.rom_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      act_q      <= '0;
      acc_q      <= '0;
      ph_q       <= '0;
      w1_q       <= WAVE_SIN;
      v1_q       <= 1'b0;
      ph2_q      <= '0;
      w2_q       <= WAVE_SIN;
      v2_q       <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      act_q      <= act_d;
      acc_q      <= acc_d;
      ph_q       <= ph_d;
      w1_q       <= w1_d;
      v1_q       <= v1_d;
      ph2_q      <= ph2_d;
      w2_q       <= w2_d;
      v2_q       <= v2_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ack_q      <= ack_d;
    end
  end

  assign bus.cfg_ack    = ack_q;
  assign bus.rom_addr   = ph_q;
  assign bus.data_out   = data_q;
  assign bus.data_valid = valid_q;

endmodule

// File: tb/tb_dds_wave_gen.sv
// Bench for dds_wave_gen at default widths: future-indexed sample model, per-cycle compare, literal pins.
module tb_dds_wave_gen;
  import dds_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dds_wave_gen_if bus ();

  dds_wave_gen dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // External registered sine ROM, signed two's-complement contents.
  logic [7:0] rom_tbl [256];
  always @(posedge clk) bus.rom_q <= rom_tbl[bus.rom_addr];

  int checks = 0;
  int errors = 0;

  int unsigned cyc = 0;
  int unsigned m_acc = 0, m_f = 0, m_p = 0, m_w = 0, m_div = 0, m_cnt = 0;
  int unsigned pf = 0, pp = 0, pw = 0, pd = 0;
  bit          m_pend = 1'b0;
  logic [7:0]  m_addr = 8'h00;
  logic [7:0]  exp_data = 8'h00;
  bit          exp_valid = 1'b0;
  bit          exp_ack = 1'b0;
  logic [7:0]  exp_at [int unsigned];

  logic [7:0]  obs_val [$];
  int unsigned obs_cyc [$];
  int unsigned ack_cyc [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: actual %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] model_sample(int unsigned w, int unsigned ph);
    case (w)
      0:       return rom_tbl[ph];
      1:       return (ph >= 128) ? 8'hFF : 8'h00;
      2:       return (ph < 128) ? 8'(2 * ph) : 8'(2 * (255 - ph) + 1);
      default: return 8'(ph);
    endcase
  endfunction

  // Reference model: one update per clock edge; samples are filed under the cycle they must appear.
  initial begin
    bit tick, apply;
    int unsigned uf, up, uw, ph;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_acc = 0; m_f = 0; m_p = 0; m_w = 0; m_div = 0; m_cnt = 0;
        pf = 0; pp = 0; pw = 0; pd = 0; m_pend = 0;
        m_addr = 0; exp_data = 0; exp_valid = 0; exp_ack = 0;
        exp_at.delete();
        if (clk) cyc++;
      end else begin
        cyc++;
        tick  = bus.en && !bus.sync_clr && (m_cnt == m_div);
        apply = m_pend && (tick || !bus.en);
        uf = apply ? pf : m_f;
        up = apply ? pp : m_p;
        uw = apply ? pw : m_w;
        if (tick) begin
          ph = ((m_acc >> 16) + up) % 256;
          exp_at[cyc + 2] = model_sample(uw, ph);
          m_addr = 8'(ph);
          m_acc = (m_acc + uf) % (1 << 24);
        end
        if (bus.sync_clr) m_acc = 0;
        if (bus.sync_clr || tick || apply) m_cnt = 0;
        else if (bus.en) m_cnt++;
        exp_ack = apply;
        if (apply) begin
          m_f = pf; m_p = pp; m_w = pw; m_div = pd; m_pend = 0;
        end
        if (bus.cfg_load) begin
          m_pend = 1;
          pf = bus.f_word; pp = bus.p_word; pw = int'(bus.wave_sel); pd = bus.div_ratio;
        end
        exp_valid = exp_at.exists(cyc);
        if (exp_valid) begin
          exp_data = exp_at[cyc];
          exp_at.delete(cyc);
        end
      end
    end
  end

  // Compare process: every output, every cycle, mid-way between active edges.
  initial begin
    forever begin
      @(negedge clk);
      check("data_valid", bus.data_valid, exp_valid);
      check("data_out",   bus.data_out,   exp_data);
      check("cfg_ack",    bus.cfg_ack,    exp_ack);
      check("rom_addr",   bus.rom_addr,   m_addr);
      if (bus.data_valid) begin
        obs_val.push_back(bus.data_out);
        obs_cyc.push_back(cyc);
      end
      if (bus.cfg_ack) ack_cyc.push_back(cyc);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic load_cfg(input logic [23:0] f, input logic [7:0] p, input wave_sel_t w,
                          input logic [7:0] d);
    bus.f_word = f; bus.p_word = p; bus.wave_sel = w; bus.div_ratio = d;
    bus.cfg_load = 1'b1;
    step(1);
    bus.cfg_load = 1'b0;
  endtask

  // Stop, drain, apply a config while idle, and clear phase and divider.
  task automatic setup(input logic [23:0] f, input logic [7:0] p, input wave_sel_t w,
                       input logic [7:0] d);
    bus.en = 1'b0;
    step(4);
    load_cfg(f, p, w, d);
    step(1);
    bus.sync_clr = 1'b1;
    step(1);
    bus.sync_clr = 1'b0;
  endtask

  initial begin
    int ob, ab, n;
    int unsigned c0, w0;
    for (int i = 0; i < 256; i++) begin
      real r;
      r = 127.0 * $sin(2.0 * 3.141592653589793 * i / 256.0);
      rom_tbl[i] = 8'(int'(r));
    end
    bus.en = 0; bus.sync_clr = 0; bus.cfg_load = 0;
    bus.f_word = 0; bus.p_word = 0; bus.wave_sel = WAVE_SIN; bus.div_ratio = 0;
    bus.rom_q = 0;

    step(3);
    check("rst_data_out", bus.data_out, 0);
    check("rst_valid",    bus.data_valid, 0);
    check("rst_ack",      bus.cfg_ack, 0);
    check("rst_rom_addr", bus.rom_addr, 0);
    rst_n = 1'b1;
    step(2);

    // Sawtooth from reset: one pre-apply sample, then +1 per sample.
    ob = obs_val.size(); ab = ack_cyc.size(); c0 = cyc;
    bus.en = 1'b1;
    load_cfg(24'h010000, 8'h00, WAVE_SAW, 8'd0);
    step(8);
    check("saw_ack_lat",   ack_cyc[ab] - c0, 2);
    check("saw_valid_lat", obs_cyc[ob] - c0, 3);
    check("saw_s0", obs_val[ob],     8'h00);
    check("saw_s1", obs_val[ob + 1], 8'h00);
    check("saw_s2", obs_val[ob + 2], 8'h01);
    check("saw_s3", obs_val[ob + 3], 8'h02);

    // Divider 3: a sample every 4th cycle; idle window; resume.
    setup(24'h010000, 8'h00, WAVE_SAW, 8'd3);
    ob = obs_val.size();
    bus.en = 1'b1;
    step(30);
    for (int i = 0; i < 4; i++)
      check("div_spacing", obs_cyc[ob + i + 1] - obs_cyc[ob + i], 4);
    w0 = cyc;
    bus.en = 1'b0;
    step(10);
    n = 0;
    foreach (obs_cyc[i]) if (obs_cyc[i] > w0 + 2) n++;
    check("idle_valids", n, 0);
    bus.en = 1'b1;
    step(20);

    // Square at half-rate step, then with the phase inverted.
    setup(24'h800000, 8'h00, WAVE_SQR, 8'd0);
    ob = obs_val.size();
    bus.en = 1'b1;
    step(8);
    check("sqr_s0", obs_val[ob],     8'h00);
    check("sqr_s1", obs_val[ob + 1], 8'hFF);
    check("sqr_s2", obs_val[ob + 2], 8'h00);
    check("sqr_s3", obs_val[ob + 3], 8'hFF);
    setup(24'h800000, 8'h80, WAVE_SQR, 8'd0);
    ob = obs_val.size();
    bus.en = 1'b1;
    step(8);
    check("sqr_inv_s0", obs_val[ob],     8'hFF);
    check("sqr_inv_s1", obs_val[ob + 1], 8'h00);

    // Triangle over a full phase turn and past the accumulator wrap.
    setup(24'h010000, 8'h00, WAVE_TRI, 8'd0);
    ob = obs_val.size();
    bus.en = 1'b1;
    step(262);
    check("tri_count", obs_val.size() >= ob + 257, 1);
    check("tri_0",   obs_val[ob],       8'h00);
    check("tri_1",   obs_val[ob + 1],   8'h02);
    check("tri_127", obs_val[ob + 127], 8'hFE);
    check("tri_128", obs_val[ob + 128], 8'hFF);
    check("tri_129", obs_val[ob + 129], 8'hFD);
    check("tri_255", obs_val[ob + 255], 8'h01);
    check("tri_256", obs_val[ob + 256], 8'h00);

    // Two loads before one tick: one ack, last step wins.
    setup(24'h000000, 8'h00, WAVE_SAW, 8'd3);
    bus.sync_clr = 1'b1; bus.en = 1'b1;
    step(1);
    bus.sync_clr = 1'b0;
    ab = ack_cyc.size();
    load_cfg(24'h010000, 8'h00, WAVE_SAW, 8'd3);
    load_cfg(24'h020000, 8'h00, WAVE_SAW, 8'd3);
    step(20);
    check("dbl_ack_count", ack_cyc.size() - ab, 1);
    n = obs_val.size();
    check("dbl_step", 8'(obs_val[n - 1] - obs_val[n - 2]), 8'h02);

    // Load coincident with a tick waits for the following tick.
    bus.sync_clr = 1'b1;
    step(1);
    bus.sync_clr = 1'b0;
    step(3);
    c0 = cyc; ab = ack_cyc.size();
    load_cfg(24'h030000, 8'h00, WAVE_SAW, 8'd3);
    step(10);
    check("coinc_ack_count", ack_cyc.size() - ab, 1);
    check("coinc_ack_lat", ack_cyc[ab] - c0, 5);

    // sync_clr while running: phase restarts at the offset.
    setup(24'h010000, 8'h30, WAVE_SAW, 8'd0);
    bus.en = 1'b1;
    step(20);
    bus.sync_clr = 1'b1;
    step(1);
    bus.sync_clr = 1'b0;
    step(1);
    check("clr_addr0", bus.rom_addr, 8'h30);
    step(1);
    check("clr_addr1", bus.rom_addr, 8'h31);

    // Randomised traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      bus.en = ($urandom_range(0, 9) != 0);
      bus.sync_clr = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 19) == 0) begin
        bus.f_word = ($urandom_range(0, 1) == 0) ? 24'($urandom)
                                                 : 24'($urandom_range(0, 4) << 16);
        bus.p_word = 8'($urandom);
        bus.wave_sel = wave_sel_t'(2'($urandom_range(0, 3)));
        bus.div_ratio = 8'($urandom_range(0, 3));
        bus.cfg_load = 1'b1;
      end else begin
        bus.cfg_load = 1'b0;
      end
      step(1);
    end
    bus.cfg_load = 1'b0; bus.sync_clr = 1'b0;

    // Asynchronous reset with the pipeline full and an ack in flight.
    setup(24'h010000, 8'h30, WAVE_SAW, 8'd0);
    bus.en = 1'b1;
    step(6);
    load_cfg(24'h010000, 8'h40, WAVE_SAW, 8'd0);
    step(1);
    check("pre_rst_ack",   bus.cfg_ack, 1);
    check("pre_rst_valid", bus.data_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid",    bus.data_valid, 0);
    check("arst_ack",      bus.cfg_ack, 0);
    check("arst_data_out", bus.data_out, 0);
    check("arst_rom_addr", bus.rom_addr, 0);
    bus.en = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(3);
    check("post_rst_valid", bus.data_valid, 0);
    check("post_rst_data",  bus.data_out, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
